lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding data-memory op, with byte-lane
// steering for stores, load extension, misalignment detection and response timeout.
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [2:0]  ex_mem_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        lsu_busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        timeout_err
);

  // state | meaning
  // IDLE  | waiting for an op from EX
  // REQ   | request driven, holding until dmem_gnt
  // RESP  | load granted, waiting for dmem_rvalid or timeout

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [4:0]    rd_q;

  logic        accept, mis_fire, wb_fire, tmo_fire;
  logic        ex_misalign, is_store;
  logic [31:0] shifted, load_data;

  always_comb begin
    ex_misalign = 1'b0;
    case (ex_mem_op)
      OP_LH, OP_LHU, OP_SH: ex_misalign = ex_addr[0];
      OP_LW, OP_SW:         ex_misalign = |ex_addr[1:0];
      default:              ex_misalign = 1'b0;
    endcase
  end

  assign is_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    mis_fire = 1'b0;
    wb_fire  = 1'b0;
    tmo_fire = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          accept = 1'b1;
          if (ex_misalign) mis_fire = 1'b1;
          else             state_d  = REQ;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          cnt_d   = '0;
          state_d = is_store ? IDLE : RESP;
        end
      end
      RESP: begin
        // rvalid takes priority over an expiring timer in the same cycle
        if (dmem_rvalid) begin
          wb_fire = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_fire = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      cnt_q        <= cnt_d;
      wb_valid     <= wb_fire;
      misalign_err <= mis_fire;
      timeout_err  <= tmo_fire;
      if (accept) begin
        op_q    <= ex_mem_op;
        addr_q  <= ex_addr;
        wdata_q <= ex_wdata;
        rd_q    <= ex_rd;
      end
      if (wb_fire) begin
        wb_rd   <= rd_q;
        wb_data <= load_data;
      end
    end
  end

  assign shifted = dmem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = dmem_rdata;
    case (op_q)
      OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_data = {24'd0, shifted[7:0]};
      OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_data = {16'd0, shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  assign lsu_busy  = (state != IDLE);
  assign dmem_req  = (state == REQ);
  assign dmem_we   = dmem_req & is_store;
  assign dmem_addr = dmem_req ? {addr_q[31:2], 2'b00} : 32'd0;

  // Request fields are forced to zero outside REQ so reset and idle look identical
  always_comb begin
    dmem_be    = 4'd0;
    dmem_wdata = 32'd0;
    if (dmem_req) begin
      case (op_q)
        OP_SB: begin
          dmem_be    = 4'b0001 << addr_q[1:0];
          dmem_wdata = {4{wdata_q[7:0]}};
        end
        OP_SH: begin
          dmem_be    = 4'b0011 << addr_q[1:0];
          dmem_wdata = {2{wdata_q[15:0]}};
        end
        OP_SW: begin
          dmem_be    = 4'b1111;
          dmem_wdata = wdata_q;
        end
        default: dmem_be = 4'b1111;
      endcase
    end
  end

endmodule
